// File: rtl/pu_pkg.sv
// Shared constants and state encoding for the neuron processing unit and its sequencer.
package pu_pkg;

  localparam int NUM_NEURONS   = 30;
  localparam int ROUNDS        = 8;
  localparam int RND_W         = 4;
  localparam int IDX_W         = 5;
  localparam int NEURON_INPUTS = 62;
  localparam int DATA_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CLR  = 3'd2,
    S_ACC  = 3'd3,
    S_CAP  = 3'd4,
    S_WB   = 3'd5,
    S_DONE = 3'd6
  } state_e;

endpackage

// File: rtl/pu_sequencer_mod_counter.sv
// Modulo counter with clear priority; last flags the terminal count MAX.
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == WIDTH'(MAX));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc)
      cnt_d = last ? '0 : cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pu_sequencer.sv
// Control sequencer for one PU datapath: fetch bundle, run MAC rounds, capture and
// hand off one activation per neuron, then pulse done.
module pu_sequencer
  import pu_pkg::*;
#(
  parameter int NUM_NEURONS = pu_pkg::NUM_NEURONS,
  parameter int ROUNDS      = pu_pkg::ROUNDS,
  parameter int IDX_W       = pu_pkg::IDX_W,
  parameter int RND_W       = pu_pkg::RND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              data_req,
  input  logic              data_ack,
  output logic [IDX_W-1:0]  neuron_idx,
  output logic              read_data_reg_ld,
  output logic              acc_rst,
  output logic              ld,
  output logic [RND_W-1:0]  round,
  output logic              mult_done,
  input  logic [DATA_W-1:0] pu_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] result_data,
  output logic [IDX_W-1:0]  result_idx
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_data_q;
  logic [IDX_W-1:0]  result_idx_q;
  logic              rnd_last, nrn_last;
  logic              xfer;

  assign xfer = (state_q == S_WB) && result_ready;

  // Round index: cleared in CLR, advanced through ACC, parked on the last round.
  mod_counter #(.WIDTH(RND_W), .MAX(ROUNDS-1)) u_rnd (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == S_CLR),
    .inc  ((state_q == S_ACC) && !rnd_last),
    .cnt  (round),
    .last (rnd_last)
  );

  // Neuron index: zeroed at pass start and on the way back to IDLE.
  mod_counter #(.WIDTH(IDX_W), .MAX(NUM_NEURONS-1)) u_nrn (
    .clk  (clk),
    .rst  (rst),
    .clr  (((state_q == S_IDLE) && start) || (state_q == S_DONE)),
    .inc  (xfer && !nrn_last),
    .cnt  (neuron_idx),
    .last (nrn_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_REQ;
      S_REQ:   if (data_ack) state_d = S_CLR;
      S_CLR:                 state_d = S_ACC;
      S_ACC:   if (rnd_last) state_d = S_CAP;
      S_CAP:                 state_d = S_WB;
      S_WB:    if (xfer)     state_d = nrn_last ? S_DONE : S_REQ;
      S_DONE:                state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      result_data_q <= '0;
      result_idx_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_CAP) begin
        result_data_q <= pu_out;
        result_idx_q  <= neuron_idx;
      end
    end
  end

  // Controls decode straight off the state flops; IDLE decodes to all zeros.
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign data_req         = (state_q == S_REQ);
  assign read_data_reg_ld = data_req && data_ack;
  assign acc_rst          = (state_q == S_CLR);
  assign ld               = (state_q == S_ACC);
  assign mult_done        = ld && rnd_last;
  assign result_valid     = (state_q == S_WB);
  assign result_data      = result_data_q;
  assign result_idx       = result_idx_q;

  a_ctrl_excl: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ld, acc_rst, read_data_reg_ld}));

  a_wb_stable: assert property (@(posedge clk) disable iff (rst)
    (result_valid && !result_ready) |=> (result_valid && $stable(result_data) && $stable(result_idx)));

endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer with a 2-neuron pass; outputs sampled on the falling edge.
module tb_pu_sequencer;
  import pu_pkg::*;

  localparam int NN = 2;

  logic             clk = 1'b0;
  logic             rst, start, data_ack, result_ready;
  logic [7:0]       pu_out;
  logic             busy, done, data_req, read_data_reg_ld, acc_rst, ld, mult_done, result_valid;
  logic [IDX_W-1:0] neuron_idx, result_idx;
  logic [RND_W-1:0] round;
  logic [7:0]       result_data;

  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  int t0, lat, nx, seen, req_n, rdl_n;
  int ridx [4];
  int rdat [4];

  pu_sequencer #(.NUM_NEURONS(NN)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .data_req         (data_req),
    .data_ack         (data_ack),
    .neuron_idx       (neuron_idx),
    .read_data_reg_ld (read_data_reg_ld),
    .acc_rst          (acc_rst),
    .ld               (ld),
    .round            (round),
    .mult_done        (mult_done),
    .pu_out           (pu_out),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_data      (result_data),
    .result_idx       (result_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] flags();
    return {busy, done, data_req, read_data_reg_ld, acc_rst, ld, mult_done,
            result_valid, 3'b000};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; data_ack = 1'b0; result_ready = 1'b0; pu_out = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_flags", 32'(flags()), 32'h0);
    chk("rst_round", 32'(round), 0);
    chk("rst_nidx", 32'(neuron_idx), 0);
    chk("rst_rdata", 32'(result_data), 0);
    chk("rst_ridx", 32'(result_idx), 0);
    rst = 1'b0;
    @(negedge clk);

    // ack in IDLE must not load or start anything
    data_ack = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    chk("idle_ack_ld", 32'(read_data_reg_ld), 0);
    chk("idle_ack_req", 32'(data_req), 0);
    @(negedge clk);
    chk("idle_ack_busy", 32'(busy), 0);

    // Test 1: full pass, ack and ready tied high
    pu_out = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; t0 = cyc; nx = 0; seen = 0; lat = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      if (result_valid) begin
        if (nx < 4) begin ridx[nx] = int'(result_idx); rdat[nx] = int'(result_data); end
        nx++;
      end
      // done is seen by the consumer at the edge after this sample
      if (done) begin seen = 1; lat = cyc - t0 + 1; end
      else @(negedge clk);
    end
    chk("t1_done_seen", 32'(seen), 1);
    chk("t1_latency", 32'(lat), 25);
    chk("t1_xfers", 32'(nx), 2);
    chk("t1_idx0", 32'(ridx[0]), 0);
    chk("t1_idx1", 32'(ridx[1]), 1);
    chk("t1_data0", 32'(rdat[0]), 32'hC3);
    chk("t1_data1", 32'(rdat[1]), 32'hC3);
    @(negedge clk);
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_busy_low", 32'(busy), 0);

    // Test 2: delayed ack
    data_ack = 1'b0; pu_out = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0; req_n = 0; rdl_n = 0;
    repeat (4) begin
      req_n += int'(data_req); rdl_n += int'(read_data_reg_ld);
      @(negedge clk);
    end
    data_ack = 1'b1;
    #1;
    req_n += int'(data_req); rdl_n += int'(read_data_reg_ld);
    chk("t2_ld_on_ack", 32'(read_data_reg_ld), 1);
    @(negedge clk);
    data_ack = 1'b0;
    chk("t2_req_cycles", 32'(req_n), 5);
    chk("t2_ld_cycles", 32'(rdl_n), 1);
    chk("t2_acc_rst", 32'(acc_rst), 1);
    chk("t2_req_off", 32'(data_req), 0);
    chk("t2_ld_off", 32'(ld), 0);

    // Test 3 + 6: ACC window with stray ack/start
    result_ready = 1'b0;
    for (int r = 0; r < ROUNDS; r++) begin
      @(negedge clk);
      chk("t3_ld", 32'(ld), 1);
      chk("t3_round", 32'(round), 32'(r));
      chk("t3_mdone", 32'(mult_done), (r == ROUNDS-1) ? 1 : 0);
      chk("t3_accrst", 32'(acc_rst), 0);
      data_ack = (r == 2);
      start    = (r == 4);
    end
    data_ack = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t3_cap_ld", 32'(ld), 0);
    chk("t3_cap_mdone", 32'(mult_done), 0);
    chk("t3_cap_round", 32'(round), ROUNDS-1);
    chk("t3_cap_valid", 32'(result_valid), 0);
    pu_out = 8'h5A;
    @(negedge clk);
    pu_out = 8'hFF;
    chk("t3_valid", 32'(result_valid), 1);
    chk("t3_rdata", 32'(result_data), 32'h5A);
    chk("t3_ridx", 32'(result_idx), 0);

    // Test 4: backpressure in WB
    repeat (4) begin
      @(negedge clk);
      chk("t4_valid", 32'(result_valid), 1);
      chk("t4_rdata", 32'(result_data), 32'h5A);
      chk("t4_ridx", 32'(result_idx), 0);
      chk("t4_noreq", 32'(data_req), 0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("t4_valid_drop", 32'(result_valid), 0);
    chk("t4_req_next", 32'(data_req), 1);
    chk("t4_nidx", 32'(neuron_idx), 1);

    // Test 5: async reset in ACC round 3
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_round3", 32'(round), 3);
    rst = 1'b1;
    #1;
    chk("t5_flags", 32'(flags()), 32'h0);
    chk("t5_round", 32'(round), 0);
    chk("t5_nidx", 32'(neuron_idx), 0);
    chk("t5_rdata", 32'(result_data), 0);
    @(negedge clk);
    rst = 1'b0;
    data_ack = 1'b1; result_ready = 1'b1; pu_out = 8'h21; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_restart_req", 32'(data_req), 1);
    chk("t5_restart_nidx", 32'(neuron_idx), 0);
    nx = 0; seen = 0;
    for (int k = 0; k < 60 && seen == 0; k++) begin
      if (result_valid) begin
        if (nx < 4) begin ridx[nx] = int'(result_idx); rdat[nx] = int'(result_data); end
        nx++;
      end
      if (done) seen = 1;
      else begin
        start = (k == 5);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("t6_done_seen", 32'(seen), 1);
    chk("t6_xfers", 32'(nx), 2);
    chk("t6_idx1", 32'(ridx[1]), 1);
    chk("t6_data0", 32'(rdat[0]), 32'h21);
    repeat (3) @(negedge clk);
    chk("t6_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
